// File: rtl/ram_arbiter_if.sv
// Bus bundle for ram_arbiter: two requester ports plus the RAM command/data port.
// slave = arbiter side, master = requesters and RAM side.
interface ram_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 8
) ();
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           ram_we, ram_addr, ram_din, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           ram_we, ram_addr, ram_din, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with registered read.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module ram_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic        clk,
  input  logic        rst,
  ram_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CMD    = 2'd1;
  localparam logic [1:0] RDWAIT = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic          winner_reg;
  logic          we_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic          pick;
  logic          cmd_active;
  logic [1:0]    req_vec;
  logic [1:0]    gnt_vec;
  logic [1:0]    rvalid_vec;
  logic [DW-1:0] rdata_arr [2];

  assign req_vec = {bus.req1, bus.req0};

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign pick = !bus.req0;
`else
  logic last_winner_reg;

  // On a tie the requester that did not win last time goes next.
  assign pick = (bus.req0 && bus.req1) ? !last_winner_reg : bus.req1;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_winner_reg <= 1'b1;
    end else if (state_reg == CMD) begin
      last_winner_reg <= winner_reg;
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|req_vec) state_next = CMD;
      CMD:     state_next = we_reg ? IDLE : RDWAIT;
      RDWAIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      winner_reg <= 1'b0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && |req_vec) begin
        winner_reg <= pick;
        we_reg     <= pick ? bus.we1    : bus.we0;
        addr_reg   <= pick ? bus.addr1  : bus.addr0;
        wdata_reg  <= pick ? bus.wdata1 : bus.wdata0;
      end
    end
  end

  // Reset asserted during CMD must keep the command off the RAM port.
  assign cmd_active   = (state_reg == CMD) && !rst;
  assign bus.ram_we   = cmd_active && we_reg;
  assign bus.ram_addr = cmd_active ? addr_reg  : '0;
  assign bus.ram_din  = cmd_active ? wdata_reg : '0;
  assign bus.busy     = (state_reg != IDLE);

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic          rvalid_reg;
    logic [DW-1:0] rdata_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        rvalid_reg <= 1'b0;
        rdata_reg  <= '0;
      end else begin
        rvalid_reg <= (state_reg == RDWAIT) && (winner_reg == 1'(gi));
        if (state_reg == RDWAIT && winner_reg == 1'(gi)) begin
          rdata_reg <= bus.ram_dout;
        end
      end
    end

    assign gnt_vec[gi]    = cmd_active && (winner_reg == 1'(gi));
    assign rvalid_vec[gi] = rvalid_reg;
    assign rdata_arr[gi]  = rdata_reg;
  end

  assign bus.gnt0    = gnt_vec[0];
  assign bus.gnt1    = gnt_vec[1];
  assign bus.rvalid0 = rvalid_vec[0];
  assign bus.rvalid1 = rvalid_vec[1];
  assign bus.rdata0  = rdata_arr[0];
  assign bus.rdata1  = rdata_arr[1];

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: expected grants and read returns are queued at drive time
// and matched by a negedge monitor; a behavioural RAM with registered read sits on the RAM port.
module tb_ram_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;

  typedef struct {
    int       port;
    logic     we;
    logic [3:0] addr;
    logic [7:0] data;
    int       cyc;
  } gnt_t;

  typedef struct {
    int       port;
    logic [7:0] data;
    int       cyc;
  } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;
  logic tb_last = 1'b1;

  gnt_t gq[$];
  rd_t  rq[$];
  logic [7:0] ref_mem [16];
  logic [7:0] ram_mem [16];
  logic [7:0] ram_dout_reg;

  ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: write on edge, read data registered one cycle after the command.
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
    ram_dout_reg <= ram_mem[bus.ram_addr];
  end
  assign bus.ram_dout = ram_dout_reg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!done) begin
      gnt_t g;
      rd_t  r;
      check("gnt_onehot", 32'(bus.gnt0 & bus.gnt1), 0);
      check("rvalid_onehot", 32'(bus.rvalid0 & bus.rvalid1), 0);
      if (bus.gnt0 || bus.gnt1) begin
        check("gnt_pending", 32'(gq.size() != 0), 1);
        if (gq.size() != 0) begin
          g = gq.pop_front();
          $display("gnt  port=%0d we=%0b addr=%0h din=%0h cyc=%0d", bus.gnt1 ? 1 : 0,
                   bus.ram_we, bus.ram_addr, bus.ram_din, cyc);
          check("gnt_port", 32'(bus.gnt1), g.port);
          check("gnt_cyc", cyc, g.cyc);
          check("ram_we", 32'(bus.ram_we), 32'(g.we));
          check("ram_addr", 32'(bus.ram_addr), 32'(g.addr));
          if (g.we) check("ram_din", 32'(bus.ram_din), 32'(g.data));
        end
      end else begin
        check("ram_idle", {19'b0, bus.ram_we, bus.ram_addr, bus.ram_din}, 0);
      end
      if (bus.rvalid0 || bus.rvalid1) begin
        check("rd_pending", 32'(rq.size() != 0), 1);
        if (rq.size() != 0) begin
          r = rq.pop_front();
          $display("rd   port=%0d data=%0h cyc=%0d", bus.rvalid1 ? 1 : 0,
                   bus.rvalid1 ? bus.rdata1 : bus.rdata0, cyc);
          check("rd_port", 32'(bus.rvalid1), r.port);
          check("rd_cyc", cyc, r.cyc);
          check("rd_data", 32'(r.port == 1 ? bus.rdata1 : bus.rdata0), 32'(r.data));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int port, input bit r, input bit we,
                       input logic [3:0] a, input logic [7:0] d);
    if (port == 0) begin
      bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic push_gnt(input int port, input bit we, input logic [3:0] a,
                          input logic [7:0] d, input int gcyc, input bit keep_rd);
    gnt_t g;
    rd_t  r;
    g.port = port; g.we = we; g.addr = a; g.data = d; g.cyc = gcyc;
    gq.push_back(g);
    tb_last = port[0];
    if (we) begin
      ref_mem[a] = d;
    end else if (keep_rd) begin
      r.port = port; r.data = ref_mem[a]; r.cyc = gcyc + 2;
      rq.push_back(r);
    end
  endtask

  function automatic int tie_pick();
`ifdef RAM_ARB_FIXED_PRIO_EN
    return 0;
`else
    return tb_last ? 0 : 1;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    step();
    step();
    tb_last = 1'b1;
    check("rst_gnt_rvalid", {28'b0, bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1}, 0);
    check("rst_rdata", {16'b0, bus.rdata0, bus.rdata1}, 0);
    check("rst_ram", {19'b0, bus.ram_we, bus.ram_addr, bus.ram_din}, 0);
    check("rst_busy", 32'(bus.busy), 0);
    rst = 1'b0;
  endtask

  // One request held for a single IDLE cycle, then waits out the access.
  task automatic access(input int port, input bit we, input logic [3:0] a, input logic [7:0] d);
    drive(port, 1, we, a, d);
    push_gnt(port, we, a, d, cyc + 1, 1);
    step();
    drive(port, 0, 0, 0, 0);
    check("busy_cmd", 32'(bus.busy), 1);
    step();
    if (!we) begin
      check("busy_rdwait", 32'(bus.busy), 1);
      step();
    end
    check("busy_idle", 32'(bus.busy), 0);
  endtask

  // Both requesters write at once; the loser keeps req high until served.
  task automatic tie_write(input logic [3:0] a0, input logic [7:0] d0,
                           input logic [3:0] a1, input logic [7:0] d1);
    int w;
    int k;
    w = tie_pick();
    k = cyc;
    drive(0, 1, 1, a0, d0);
    drive(1, 1, 1, a1, d1);
    push_gnt(w, 1, w == 0 ? a0 : a1, w == 0 ? d0 : d1, k + 1, 1);
    push_gnt(1 - w, 1, w == 0 ? a1 : a0, w == 0 ? d1 : d0, k + 3, 1);
    step();
    drive(w, 0, 0, 0, 0);
    step();
    step();
    drive(1 - w, 0, 0, 0, 0);
    step();
  endtask

  initial begin
    int k;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 8'h00;
      ram_mem[i] = 8'h00;
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    do_reset();

    // Single write, then write/read on requester 1, dropped-request write/read.
    access(0, 1, 4'h3, 8'hAA);
    access(1, 1, 4'hF, 8'h5C);
    access(1, 0, 4'hF, 8'h00);
    access(0, 1, 4'h2, 8'h11);
    access(1, 0, 4'h2, 8'h00);
    access(0, 0, 4'h3, 8'h00);

    // Held contention after reset.
    do_reset();
    k = cyc;
    drive(0, 1, 1, 4'h8, 8'hC0);
    drive(1, 1, 1, 4'h9, 8'hC1);
    for (int i = 0; i < 4; i++) begin
      int w;
      w = tie_pick();
      push_gnt(w, 1, w == 0 ? 4'h8 : 4'h9, w == 0 ? 8'hC0 : 8'hC1, k + 1 + 2 * i, 1);
    end
    for (int i = 0; i < 7; i++) step();
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    step();
    access(1, 0, 4'h8, 8'h00);

    // Late request from requester 1 while requester 0 is in RDWAIT.
    k = cyc;
    drive(0, 1, 0, 4'h3, 8'h00);
    push_gnt(0, 0, 4'h3, 8'h00, k + 1, 1);
    step();
    drive(0, 0, 0, 0, 0);
    step();
    drive(1, 1, 1, 4'h6, 8'h66);
    push_gnt(1, 1, 4'h6, 8'h66, k + 4, 1);
    step();
    step();
    drive(1, 0, 0, 0, 0);
    step();

    // Reset during RDWAIT aborts the read.
    access(0, 1, 4'h0, 8'h77);
    drive(0, 1, 0, 4'h0, 8'h00);
    push_gnt(0, 0, 4'h0, 8'h00, cyc + 1, 0);
    step();
    drive(0, 0, 0, 0, 0);
    step();
    check("busy_before_rst", 32'(bus.busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    tb_last = 1'b1;
    check("busy_after_rst", 32'(bus.busy), 0);
    check("rdata0_after_rst", 32'(bus.rdata0), 0);
    access(0, 0, 4'h0, 8'h00);

    // Mixed traffic.
    for (int i = 0; i < 24; i++) begin
      int sel;
      sel = $urandom_range(0, 2);
      if (sel == 0)
        access($urandom_range(0, 1), 1, 4'($urandom_range(0, 15)), 8'($urandom));
      else if (sel == 1)
        access($urandom_range(0, 1), 0, 4'($urandom_range(0, 15)), 8'h00);
      else
        tie_write(4'($urandom_range(0, 15)), 8'($urandom),
                  4'($urandom_range(0, 15)), 8'($urandom));
    end
    for (int i = 0; i < 16; i++) access(i % 2, 0, 4'(i), 8'h00);

    step();
    step();
    done = 1'b1;
    check("gnt_left", gq.size(), 0);
    check("rd_left", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
